// File: rtl/fp_addsub_seq.sv
// fp_addsub_seq: multi-cycle floating-point add/sub/compare/move unit with
// round-to-nearest-even and a start/busy/done handshake.
module fp_addsub_seq #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [3:0]           fpu_op,
    input  logic [EXP_W+MAN_W:0] a,
    input  logic [EXP_W+MAN_W:0] b,
    output logic                 busy,
    output logic                 done,
    output logic [EXP_W+MAN_W:0] result,
    output logic                 fp_cc,
    output logic                 invalid,
    output logic                 overflow,
    output logic                 underflow
);
    localparam int W = 1 + EXP_W + MAN_W;
    localparam int X = MAN_W + 4;
    localparam logic [EXP_W-1:0] EMAX = '1;
    localparam logic [W-1:0] QNAN = {1'b0, EMAX, 1'b1, {(MAN_W-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, ROUND, DONE} state_t;

    state_t state_q, state_d;
    logic [3:0] op_q, op_d;
    logic [W-1:0] a_q, a_d, b_q, b_d, result_q, result_d;
    logic fp_cc_q, fp_cc_d, invalid_q, invalid_d, overflow_q, overflow_d;
    logic underflow_q, underflow_d, done_q, done_d;
    logic sign_q, sign_d, sub_q, sub_d, zero_q, zero_d;
    logic [EXP_W:0] exp_q, exp_d;
    logic [X-1:0] sig_q, sig_d, sml_q, sml_d;

    // Compare and mov resolve from the ports so their result lands on the accepting edge.
    logic in_nan, in_zero, mag_lt, mag_gt, c_eq, c_lt, in_add, in_cmp;
    assign in_nan = (&a[W-2:MAN_W] & |a[MAN_W-1:0]) | (&b[W-2:MAN_W] & |b[MAN_W-1:0]);
    assign in_zero = ~|a[W-2:0] & ~|b[W-2:0];
    assign mag_lt = a[W-2:0] < b[W-2:0];
    assign mag_gt = a[W-2:0] > b[W-2:0];
    assign c_eq = ~in_nan & ((a == b) | in_zero);
    assign c_lt = ~in_nan & ~in_zero & ((a[W-1] != b[W-1]) ? a[W-1] : (a[W-1] ? mag_gt : mag_lt));
    assign in_add = (fpu_op == 4'd1) | (fpu_op == 4'd2);
    assign in_cmp = (fpu_op == 4'd3) | (fpu_op == 4'd4) | (fpu_op == 4'd5);

    logic is_add, a_nan, b_nan, a_inf, b_inf, spec, spec_inv, swap;
    logic [W-1:0] bx, spec_word;
    logic [EXP_W-1:0] ae, be, big_e, sml_e, dif;
    logic [MAN_W-1:0] af, bf;
    logic [X-1:0] big_x, sml_x, sml_al;
    logic [2*X-1:0] sh;
    int sh_amt;
    assign is_add = (op_q == 4'd1) | (op_q == 4'd2);
    assign bx = {b_q[W-1] ^ (op_q == 4'd2), b_q[W-2:0]};
    assign ae = a_q[W-2:MAN_W];
    assign be = bx[W-2:MAN_W];
    assign af = (ae == '0) ? '0 : a_q[MAN_W-1:0];
    assign bf = (be == '0) ? '0 : bx[MAN_W-1:0];
    assign a_nan = &ae & |a_q[MAN_W-1:0];
    assign b_nan = &be & |bx[MAN_W-1:0];
    assign a_inf = &ae & ~|a_q[MAN_W-1:0];
    assign b_inf = &be & ~|bx[MAN_W-1:0];
    assign spec = a_nan | b_nan | a_inf | b_inf;
    assign spec_inv = a_nan | b_nan | (a_inf & b_inf & (a_q[W-1] != bx[W-1]));
    assign spec_word = spec_inv ? QNAN : (a_inf ? a_q : bx);
    assign swap = {be, bf} > {ae, af};
    assign big_e = swap ? be : ae;
    assign sml_e = swap ? ae : be;
    assign big_x = swap ? {|be, bf, 3'b000} : {|ae, af, 3'b000};
    assign sml_x = swap ? {|ae, af, 3'b000} : {|be, bf, 3'b000};
    assign dif = big_e - sml_e;
    assign sh_amt = (int'(dif) > X) ? X : int'(dif);
    // Everything shifted below the round bit collapses into sticky.
    assign sh = {sml_x, {X{1'b0}}} >> sh_amt;
    assign sml_al = {sh[2*X-1:X+1], |sh[X:0]};

    logic [X:0] sum;
    assign sum = sub_q ? {1'b0, sig_q} - {1'b0, sml_q} : {1'b0, sig_q} + {1'b0, sml_q};

    logic inc, ovf;
    logic [MAN_W+1:0] m;
    logic [EXP_W:0] exp_r;
    logic [MAN_W-1:0] frac_r;
    assign inc = sig_q[2] & (sig_q[1] | sig_q[0] | sig_q[3]);
    assign m = {1'b0, sig_q[X-1:3]} + {{(MAN_W+1){1'b0}}, inc};
    assign exp_r = exp_q + {{EXP_W{1'b0}}, m[MAN_W+1]};
    assign frac_r = m[MAN_W+1] ? m[MAN_W:1] : m[MAN_W-1:0];
    assign ovf = exp_r >= {1'b0, EMAX};

    always_comb begin
        state_d = state_q;
        op_d = op_q;
        a_d = a_q;
        b_d = b_q;
        result_d = result_q;
        fp_cc_d = fp_cc_q;
        invalid_d = invalid_q;
        overflow_d = overflow_q;
        underflow_d = underflow_q;
        done_d = 1'b0;
        sign_d = sign_q;
        sub_d = sub_q;
        zero_d = zero_q;
        exp_d = exp_q;
        sig_d = sig_q;
        sml_d = sml_q;
        case (state_q)
            IDLE: if (start && !done_q) begin
                op_d = fpu_op;
                a_d = a;
                b_d = b;
                state_d = in_add ? ALIGN : DONE;
                result_d = (fpu_op == 4'd6) ? a : '0;
                fp_cc_d = (fpu_op == 4'd3) ? c_eq : (fpu_op == 4'd4) ? c_lt : (fpu_op == 4'd5) ? (c_lt | c_eq) : 1'b0;
                invalid_d = in_cmp ? in_nan : !(in_add || fpu_op == 4'd6);
                overflow_d = 1'b0;
                underflow_d = 1'b0;
            end
            ALIGN: begin
                sign_d = swap ? bx[W-1] : a_q[W-1];
                sub_d = a_q[W-1] ^ bx[W-1];
                exp_d = {1'b0, big_e};
                sig_d = big_x;
                sml_d = sml_al;
                state_d = ADD;
            end
            ADD: begin
                sig_d = sum[X] ? {sum[X:2], sum[1] | sum[0]} : sum[X-1:0];
                exp_d = exp_q + {{EXP_W{1'b0}}, sum[X]};
                zero_d = (sum == '0);
                sign_d = sign_q & (sum != '0);
                state_d = NORM;
            end
            NORM: if (!sig_q[X-1] && exp_q > {{EXP_W{1'b0}}, 1'b1} && !spec && !zero_q) begin
                sig_d = {sig_q[X-2:0], 1'b0};
                exp_d = exp_q - {{EXP_W{1'b0}}, 1'b1};
            end else begin
                state_d = ROUND;
            end
            ROUND: begin
                state_d = DONE;
                done_d = 1'b1;
                if (spec) begin
                    result_d = spec_word;
                    invalid_d = spec_inv;
                end else if (zero_q) begin
                    result_d = '0;
                end else if (!sig_q[X-1]) begin
                    result_d = {sign_q, {(W-1){1'b0}}};
                    underflow_d = 1'b1;
                end else if (ovf) begin
                    result_d = {sign_q, EMAX, {MAN_W{1'b0}}};
                    overflow_d = 1'b1;
                end else begin
                    result_d = {sign_q, exp_r[EXP_W-1:0], frac_r};
                end
            end
            DONE: begin
                state_d = IDLE;
                done_d = !is_add;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            op_q <= '0;
            a_q <= '0;
            b_q <= '0;
            result_q <= '0;
            fp_cc_q <= 1'b0;
            invalid_q <= 1'b0;
            overflow_q <= 1'b0;
            underflow_q <= 1'b0;
            done_q <= 1'b0;
            sign_q <= 1'b0;
            sub_q <= 1'b0;
            zero_q <= 1'b0;
            exp_q <= '0;
            sig_q <= '0;
            sml_q <= '0;
        end else begin
            state_q <= state_d;
            op_q <= op_d;
            a_q <= a_d;
            b_q <= b_d;
            result_q <= result_d;
            fp_cc_q <= fp_cc_d;
            invalid_q <= invalid_d;
            overflow_q <= overflow_d;
            underflow_q <= underflow_d;
            done_q <= done_d;
            sign_q <= sign_d;
            sub_q <= sub_d;
            zero_q <= zero_d;
            exp_q <= exp_d;
            sig_q <= sig_d;
            sml_q <= sml_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign result = result_q;
    assign fp_cc = fp_cc_q;
    assign invalid = invalid_q;
    assign overflow = overflow_q;
    assign underflow = underflow_q;
endmodule
